// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 9;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, trial-subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh_s;
  logic [WIDTH:0] trial_s;

  // rem_i < divisor_i keeps the shifted remainder below 2*divisor, so a
  // WIDTH+1 bit difference is exact and its MSB is the borrow.
  always_comb begin
    rem_sh_s = {rem_i, quo_i[WIDTH-1]};
    trial_s  = rem_sh_s - {1'b0, divisor_i};
    if (trial_s[WIDTH]) begin
      rem_o = rem_sh_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = trial_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_9bit_seq.sv
// Iterative unsigned divider with valid/ready handshakes; one restoring step per cycle.
module div_9bit_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divByZero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             inready_q, inready_d;
  logic             outvalid_q, outvalid_d;

  logic [WIDTH-1:0] step_rem_s;
  logic [WIDTH-1:0] step_quo_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem_s),
    .quo_o     (step_quo_s)
  );

  // Next-state, datapath and registered-handshake logic.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (inValid) begin
          dvs_d = divisor;
          if (divisor == {WIDTH{1'b0}}) begin
            quotient_d  = {WIDTH{1'b1}};
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            rem_d   = {WIDTH{1'b0}};
            quo_d   = dividend;
            cnt_d   = CNT_W'(WIDTH - 1);
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        rem_d = step_rem_s;
        quo_d = step_quo_s;
        if (cnt_q == {CNT_W{1'b0}}) begin
          quotient_d  = step_quo_s;
          remainder_d = step_rem_s;
          dbz_d       = 1'b0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (outReady) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    inready_d  = (state_d == IDLE);
    outvalid_d = (state_d == DONE);
  end

  // State, datapath and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= {WIDTH{1'b0}};
      quo_q       <= {WIDTH{1'b0}};
      dvs_q       <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
      inready_q   <= 1'b1;
      outvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      inready_q   <= inready_d;
      outvalid_q  <= outvalid_d;
    end
  end

  assign inReady   = inready_q;
  assign outValid  = outvalid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign divByZero = dbz_q;

endmodule
